// File: rtl/fifo_ctrl_pkg.sv
// Shared state codes for the FIFO sequencing controller.
// Imported by the controller top and its pointer sub-block.
package fifo_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   function automatic logic ops_allowed(input state_t s);
      return (s == ST_IDLE) || (s == ST_ACTIVE);
   endfunction

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Wrapping address counter for one side of the FIFO array.
// Advances by one per accepted operation, cleared by sync reset.
module fifo_ctrl_ptr #(
   parameter int width = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [width-1:0] ptr
);

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_controller.sv
// Push/pop sequencing, occupancy and flag logic for the FIFO array.
// Enables are combinational; everything else is registered.
module fifo_controller
   import fifo_ctrl_pkg::*;
#(
   parameter int address_width = 2,
   parameter int data_width    = 6
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   init,
   input  logic                   push,
   input  logic                   pop,
   input  logic [address_width:0] almost_full_th,
   input  logic [address_width:0] almost_empty_th,
   output logic                   wr_enable,
   output logic                   rd_enable,
   output logic [address_width-1:0] wr_ptr,
   output logic [address_width-1:0] rd_ptr,
   output logic [address_width:0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic                   data_valid,
   output logic                   error,
   output logic [2:0]             state
);

   localparam logic [address_width:0] DEPTH =
      (address_width+1)'(1) << address_width;

   state_t cur, nxt;
   logic   bad;
   logic [address_width:0] cnt_next;
   logic [address_width:0] af_q, ae_q, af_n, ae_n;

   assign state = cur;

   fifo_ctrl_ptr #(.width(address_width)) u_wr (
      .clk   (clk),
      .reset (reset),
      .inc   (wr_enable),
      .ptr   (wr_ptr)
   );

   fifo_ctrl_ptr #(.width(address_width)) u_rd (
      .clk   (clk),
      .reset (reset),
      .inc   (rd_enable),
      .ptr   (rd_ptr)
   );

   // Acceptance uses the registered flags of the current occupancy
   always_comb begin
      wr_enable = 1'b0;
      rd_enable = 1'b0;
      bad       = 1'b0;
      if (ops_allowed(cur)) begin
         wr_enable = push && !full;
         rd_enable = pop && !empty;
         bad       = (push && full) || (pop && empty);
      end
   end

   always_comb begin
      cnt_next = count;
      if (wr_enable && !rd_enable) begin
         cnt_next = count + 1'b1;
      end else if (rd_enable && !wr_enable) begin
         cnt_next = count - 1'b1;
      end
   end

   assign af_n = (cur == ST_INIT) ? almost_full_th  : af_q;
   assign ae_n = (cur == ST_INIT) ? almost_empty_th : ae_q;

   always_comb begin
      nxt = cur;
      unique case (cur)
         ST_RESET: nxt = ST_INIT;
         ST_INIT: begin
            if (!init) nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (bad)            nxt = ST_ERROR;
            else if (wr_enable) nxt = ST_ACTIVE;
            else if (init)      nxt = ST_INIT;
         end
         ST_ACTIVE: begin
            if (bad)
               nxt = ST_ERROR;
            else if (init && count == '0)
               nxt = ST_INIT;
            else if (cnt_next == '0 && !push)
               nxt = ST_IDLE;
         end
         ST_ERROR: nxt = ST_ERROR;
         default:  nxt = ST_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur          <= ST_RESET;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         data_valid   <= 1'b0;
         error        <= 1'b0;
         af_q         <= '0;
         ae_q         <= '0;
      end else begin
         cur          <= nxt;
         count        <= cnt_next;
         full         <= (cnt_next == DEPTH);
         empty        <= (cnt_next == '0);
         almost_full  <= (cnt_next >= af_n);
         almost_empty <= (cnt_next <= ae_n);
         data_valid   <= rd_enable;
         error        <= error | bad;
         af_q         <= af_n;
         ae_q         <= ae_n;
      end
   end

endmodule

// File: tb/tb_fifo_controller.sv
// Randomized bench for fifo_controller against an occupancy/queue model.
// Directed spec scenarios first, then a long random push/pop/init/reset run.
module tb_fifo_controller;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset, init, push, pop;
   logic [AW:0]   almost_full_th, almost_empty_th;
   logic          wr_enable, rd_enable;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, almost_full, almost_empty;
   logic          data_valid, error;
   logic [2:0]    state;

   int n_vec = 0;
   int n_err = 0;

   // Model: occupancy, addresses as plain integers, queue of written slots
   int m_st, m_cnt, m_wr, m_rd, m_af, m_ae, m_dv, m_error;
   int slots[$];

   fifo_controller #(.address_width(AW), .data_width(6)) dut (
      .clk             (clk),
      .reset           (reset),
      .init            (init),
      .push            (push),
      .pop             (pop),
      .almost_full_th  (almost_full_th),
      .almost_empty_th (almost_empty_th),
      .wr_enable       (wr_enable),
      .rd_enable       (rd_enable),
      .wr_ptr          (wr_ptr),
      .rd_ptr          (rd_ptr),
      .count           (count),
      .full            (full),
      .empty           (empty),
      .almost_full     (almost_full),
      .almost_empty    (almost_empty),
      .data_valid      (data_valid),
      .error           (error),
      .state           (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cycle(input bit r, input bit i, input bit pu, input bit po,
                        input int af, input int ae);
      bit act, aw, ar, bd;
      int c0, st0, slot;
      reset = r; init = i; push = pu; pop = po;
      almost_full_th  = 3'(af);
      almost_empty_th = 3'(ae);
      act = (m_st == 2) || (m_st == 3);
      aw  = act && pu && (m_cnt < DEPTH);
      ar  = act && po && (m_cnt > 0);
      bd  = act && ((pu && m_cnt == DEPTH) || (po && m_cnt == 0));
      #1;
      chk("wr_enable", int'(wr_enable), int'(aw));
      chk("rd_enable", int'(rd_enable), int'(ar));
      @(posedge clk);
      #1;
      if (r) begin
         m_st = 0; m_cnt = 0; m_wr = 0; m_rd = 0;
         m_af = 0; m_ae = 0; m_dv = 0; m_error = 0;
         slots.delete();
      end else begin
         c0 = m_cnt; st0 = m_st;
         if (aw) begin
            slots.push_back(m_wr);
            m_wr = (m_wr + 1) % DEPTH;
         end
         if (ar) begin
            slot = (slots.size() > 0) ? slots.pop_front() : -1;
            chk("rd_slot", m_rd, slot);
            m_rd = (m_rd + 1) % DEPTH;
         end
         m_cnt = m_cnt + int'(aw) - int'(ar);
         if (st0 == 1) begin
            m_af = af; m_ae = ae;
         end
         m_dv = int'(ar);
         if (bd) m_error = 1;
         case (st0)
            0: m_st = 1;
            1: if (!i) m_st = 2;
            2: if (bd) m_st = 4; else if (aw) m_st = 3; else if (i) m_st = 1;
            3: if (bd) m_st = 4;
               else if (i && c0 == 0) m_st = 1;
               else if (m_cnt == 0 && !pu) m_st = 2;
            default: m_st = m_st;
         endcase
      end
      chk("state", int'(state), m_st);
      chk("count", int'(count), m_cnt);
      chk("wr_ptr", int'(wr_ptr), m_wr);
      chk("rd_ptr", int'(rd_ptr), m_rd);
      chk("full", int'(full), r ? 0 : int'(m_cnt == DEPTH));
      chk("empty", int'(empty), int'(m_cnt == 0));
      chk("almost_full", int'(almost_full), r ? 0 : int'(m_cnt >= m_af));
      chk("almost_empty", int'(almost_empty), r ? 1 : int'(m_cnt <= m_ae));
      chk("data_valid", int'(data_valid), m_dv);
      chk("error", int'(error), m_error);
      @(negedge clk);
   endtask

   task automatic do_init(input int af, input int ae);
      cycle(1, 0, 0, 0, af, ae);
      cycle(1, 0, 0, 0, af, ae);
      cycle(0, 1, 0, 0, af, ae);
      cycle(0, 1, 0, 0, af, ae);
      cycle(0, 0, 0, 0, af, ae);
   endtask

   initial begin
      bit r, i, pu, po;
      reset = 1'b1; init = 1'b0; push = 1'b0; pop = 1'b0;
      almost_full_th = '0; almost_empty_th = '0;
      m_st = 0; m_cnt = 0; m_wr = 0; m_rd = 0;
      m_af = 0; m_ae = 0; m_dv = 0; m_error = 0;
      @(negedge clk);

      do_init(3, 1);
      chk("init_idle", int'(state), 2);
      chk("init_empty", int'(empty), 1);
      chk("init_aempty", int'(almost_empty), 1);

      for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 3, 1);
      chk("af_at_3", int'(almost_full), 1);
      cycle(0, 0, 1, 0, 3, 1);
      chk("full_4", int'(full), 1);
      chk("wr_wrap", int'(wr_ptr), 0);

      for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 3, 1);
      chk("rd_wrap", int'(rd_ptr), 0);
      chk("drain_idle", int'(state), 2);

      cycle(0, 0, 1, 0, 3, 1);
      cycle(0, 0, 1, 0, 3, 1);
      for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1, 3, 1);
      chk("pp_count", int'(count), 2);
      chk("pp_wr", int'(wr_ptr), 1);
      chk("pp_rd", int'(rd_ptr), 3);

      cycle(0, 0, 1, 0, 3, 1);
      cycle(0, 0, 1, 0, 3, 1);
      cycle(0, 0, 1, 0, 3, 1);
      chk("ovf_state", int'(state), 4);
      chk("ovf_error", int'(error), 1);
      cycle(0, 0, 1, 1, 3, 1);
      cycle(0, 0, 0, 1, 3, 1);

      do_init(3, 1);
      cycle(0, 0, 0, 1, 3, 1);
      chk("udf_error", int'(error), 1);

      do_init(3, 1);
      for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 3, 1);
      cycle(1, 0, 1, 0, 3, 1);
      chk("mid_rst_cnt", int'(count), 0);
      chk("mid_rst_wr", int'(wr_ptr), 0);

      do_init(5, 2);
      for (int k = 0; k < 800; k++) begin
         r  = ($urandom_range(0, 99) < 2) ||
              (m_error == 1 && $urandom_range(0, 3) == 0);
         i  = (m_st == 1) ? ($urandom_range(0, 1) == 1)
                          : ($urandom_range(0, 99) < 4);
         pu = $urandom_range(0, 99) < 55;
         po = $urandom_range(0, 99) < 45;
         cycle(r, i, pu, po, int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
